lane_deskew_buffer: RTL and testbench
=====================================

LANE_DESKEW_BUFFER -- requirements
Module: lane_deskew_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- NumLanes, 4, number of independently delayed lanes
- LaneWidth, 8, data bits per lane
- FifoDepth, 4, entries per lane FIFO (power of two, >=2)
- MaxSkew, 8, max cycles a partial word may wait (>=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk_i, in, 1, sole clock
- rst_ni, in, 1, asynchronous active-low reset
- clear_i, in, 1, synchronous flush of FIFOs, skew counter and sticky flags
- lane_valid_i, in, NumLanes, per-lane beat strobe from the channel (no backpressure)
- lane_data_i, in, NumLanes*LaneWidth, lane k at bits [k*LaneWidth +: LaneWidth]
- valid_o, out, 1, aligned word available
- ready_i, in, 1, downstream accepts word
- data_o, out, NumLanes*LaneWidth, aligned word, same lane packing
- overflow_o, out, NumLanes, sticky per-lane overflow flag
- skew_err_o, out, 1, sticky skew-timeout flag

Function
REQ-003 Each lane SHALL own a FifoDepth-entry FIFO with a count of width clog2(FifoDepth)+1 and wrapping read/write pointers.
REQ-004 A beat with lane_valid_i[k]=1 SHALL be written on the rising edge and SHALL become visible at the FIFO head one cycle later (no combinational input-to-output path).
REQ-005 valid_o SHALL be 1 iff all lane FIFOs are non-empty; data_o SHALL be the concatenation of the lane FIFO heads; data_o is don't-care when valid_o=0.
REQ-006 On valid_o=1 and ready_i=1, every lane FIFO SHALL pop exactly one entry in the same edge.
REQ-007 A push to a full lane SHALL be accepted only if that lane pops in the same cycle; otherwise the beat SHALL be dropped, and overflow_o[k] SHALL be set on the next edge and held until clear_i or reset.
REQ-008 Simultaneous push and pop on a non-full, non-empty lane SHALL leave that lane's count unchanged.
REQ-009 The skew controller SHALL have states IDLE (all lanes empty), WAIT (at least one lane non-empty, valid_o=0) and ALIGNED (valid_o=1).
REQ-010 In WAIT, a skew counter (width clog2(MaxSkew+1)) SHALL increment each cycle; in IDLE or ALIGNED it SHALL be 0.
REQ-011 When the counter equals MaxSkew while in WAIT, the next edge SHALL flush all lane FIFOs, set skew_err_o, clear the counter and return to IDLE; lane inputs in that cycle SHALL be dropped without setting overflow_o.
REQ-012 clear_i=1 SHALL, on the next edge, empty all FIFOs, zero the counter, clear overflow_o and skew_err_o, and enter IDLE; it SHALL take priority over push, pop and skew flush.
REQ-013 Pointers SHALL wrap from FifoDepth-1 to 0 without loss of ordering.

Reset
REQ-014 rst_ni=0 SHALL asynchronously empty all FIFOs, zero pointers and counter, enter IDLE, and drive valid_o=0, overflow_o=0, skew_err_o=0.
REQ-015 A reset asserted mid-operation SHALL discard all buffered beats; no word SHALL be emitted until a full new set of lane beats is received after deassertion.
REQ-016 FIFO storage contents SHALL NOT require reset.

Verification
REQ-017 Deskew: lanes 0..3 receive 0xA0..0xA3 at cycles 0,2,3,5, ready_i=1 -> valid_o=1 only at cycle 6 with data_o=0xA3A2A1A0, then valid_o=0.
REQ-018 Backpressure/overflow: ready_i=0, lane 1 receives 5 beats, others idle -> 4 beats stored, overflow_o=0b0010 from the cycle after the 5th beat; valid_o stays 0.
REQ-019 Skew timeout: MaxSkew=8, only lane 0 receives a beat at cycle 0 -> skew_err_o=1 and lane 0 empty at cycle 10; valid_o never asserts.
REQ-020 Full-lane push+pop: all lanes full, ready_i=1, all lanes push -> no overflow, counts stay 4, words emitted in order across pointer wrap.
REQ-021 clear_i during WAIT with overflow_o=0b0001 -> next cycle all FIFOs empty, overflow_o=0, skew_err_o=0, counter 0.
REQ-022 rst_ni pulse while 2 words are buffered -> valid_o=0 immediately; the next word emitted equals the first complete set of lane beats received after reset.

Source files
------------

// File: rtl/lane_deskew_buffer.sv
// Multi-lane deskew buffer: per-lane FIFOs absorb channel skew and emit a word once every lane has a beat.
// A skew timeout flushes partial words that wait too long.
module lane_deskew_buffer #(
    parameter int unsigned NumLanes  = 4,
    parameter int unsigned LaneWidth = 8,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned MaxSkew   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic [NumLanes-1:0]           lane_valid_i,
    input  logic [NumLanes*LaneWidth-1:0] lane_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NumLanes*LaneWidth-1:0] data_o,
    output logic [NumLanes-1:0]           overflow_o,
    output logic                          skew_err_o
);
    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SkewW = $clog2(MaxSkew + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ALIGNED} state_e;

    state_e               state_q, state_d;
    logic [LaneWidth-1:0] mem_q    [NumLanes][FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q [NumLanes];
    logic [PtrW-1:0]      rd_ptr_q [NumLanes];
    logic [CntW-1:0]      count_q  [NumLanes];
    logic [CntW-1:0]      count_d  [NumLanes];
    logic [SkewW-1:0]     skew_cnt_q, skew_cnt_d;
    logic [NumLanes-1:0]  full, push, ovf_set, nonempty_d;
    logic                 pop, skew_flush, flush;

    // State always mirrors the registered lane occupancy, so ALIGNED means every lane has a head.
    assign valid_o    = (state_q == ST_ALIGNED);
    assign pop        = valid_o & ready_i;
    assign skew_flush = (state_q == ST_WAIT) && (skew_cnt_q == SkewW'(MaxSkew));
    assign flush      = clear_i | skew_flush;

    // Per-lane push/drop decision and next occupancy; a full lane only accepts when it pops too.
    always_comb begin
        full       = '0;
        push       = '0;
        ovf_set    = '0;
        nonempty_d = '0;
        for (int k = 0; k < NumLanes; k++) begin
            full[k]       = (count_q[k] == CntW'(FifoDepth));
            push[k]       = lane_valid_i[k] & ~flush & (~full[k] | pop);
            ovf_set[k]    = lane_valid_i[k] & ~flush & full[k] & ~pop;
            count_d[k]    = flush ? '0 : count_q[k] + CntW'(push[k]) - CntW'(pop);
            nonempty_d[k] = (count_d[k] != '0);
        end
    end

    // Skew controller next state, classified from next-cycle occupancy.
    always_comb begin
        state_d    = ST_IDLE;
        skew_cnt_d = '0;
        if (&nonempty_d) begin
            state_d = ST_ALIGNED;
        end else if (|nonempty_d) begin
            state_d = ST_WAIT;
        end
        if (state_d == ST_WAIT && state_q == ST_WAIT) begin
            skew_cnt_d = skew_cnt_q + SkewW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            skew_cnt_q <= '0;
            overflow_o <= '0;
            skew_err_o <= 1'b0;
            for (int k = 0; k < NumLanes; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            skew_cnt_q <= skew_cnt_d;
            if (clear_i) begin
                overflow_o <= '0;
                skew_err_o <= 1'b0;
            end else begin
                overflow_o <= overflow_o | ovf_set;
                if (skew_flush) begin
                    skew_err_o <= 1'b1;
                end
            end
            for (int k = 0; k < NumLanes; k++) begin
                count_q[k] <= count_d[k];
                if (flush) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                end else begin
                    if (push[k]) begin
                        wr_ptr_q[k] <= wr_ptr_q[k] + PtrW'(1);
                    end
                    if (pop) begin
                        rd_ptr_q[k] <= rd_ptr_q[k] + PtrW'(1);
                    end
                end
            end
        end
    end

    // Lane storage holds no control meaning, so it is left unreset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumLanes; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= lane_data_i[k*LaneWidth +: LaneWidth];
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int k = 0; k < NumLanes; k++) begin
            data_o[k*LaneWidth +: LaneWidth] = mem_q[k][rd_ptr_q[k]];
        end
    end

endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Self-checking bench for lane_deskew_buffer against a queue-based reference model.
module tb_lane_deskew_buffer;
    localparam int NL      = 4;
    localparam int LW      = 8;
    localparam int DW      = NL * LW;
    localparam int DEPTH   = 4;
    localparam int MAXSKEW = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic [NL-1:0] lane_valid_i;
    logic [DW-1:0] lane_data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic [NL-1:0] overflow_o;
    logic          skew_err_o;

    int errors = 0;
    int checks = 0;

    lane_deskew_buffer #(
        .NumLanes (NL),
        .LaneWidth(LW),
        .FifoDepth(DEPTH),
        .MaxSkew  (MAXSKEW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .lane_valid_i(lane_valid_i),
        .lane_data_i (lane_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .overflow_o  (overflow_o),
        .skew_err_o  (skew_err_o)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per lane plus sticky flags and partial-word age.
    logic [LW-1:0] mq [NL][$];
    logic [NL-1:0] m_ovf;
    logic          m_skerr;
    int            m_age;

    function automatic bit m_all_ne();
        for (int k = 0; k < NL; k++) if (mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_any_ne();
        for (int k = 0; k < NL; k++) if (mq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] m_data();
        logic [DW-1:0] r = '0;
        for (int k = 0; k < NL; k++) if (mq[k].size() != 0) r[k*LW +: LW] = mq[k][0];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NL; k++) mq[k].delete();
        m_ovf   = '0;
        m_skerr = 1'b0;
        m_age   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit all_ne, part_now, part_next, pop;
        all_ne   = m_all_ne();
        part_now = m_any_ne() && !all_ne;
        if (clear_i) begin
            model_reset();
        end else if (part_now && m_age == MAXSKEW) begin
            for (int k = 0; k < NL; k++) mq[k].delete();
            m_skerr = 1'b1;
            m_age   = 0;
        end else begin
            pop = all_ne && ready_i;
            for (int k = 0; k < NL; k++) begin
                if (pop) mq[k].delete(0);
                if (lane_valid_i[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(lane_data_i[k*LW +: LW]);
                    else m_ovf[k] = 1'b1;
                end
            end
            part_next = m_any_ne() && !m_all_ne();
            m_age = (part_now && part_next) ? m_age + 1 : 0;
        end
    endtask

    task automatic drive(input logic [NL-1:0] lv, input logic [DW-1:0] ld,
                         input logic rdy, input logic clr);
        @(negedge clk);
        lane_valid_i = lv;
        lane_data_i  = ld;
        ready_i      = rdy;
        clear_i      = clr;
    endtask

    task automatic clear_cycle();
        drive('0, '0, 1'b0, 1'b1);
        model_step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive('1, DW'($urandom), 1'b1, 1'b0);
        drive('1, DW'($urandom), 1'b1, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", valid_o);
        end
        checks++;
        if (overflow_o !== '0) begin
            errors++; $display("FAIL reset_overflow got %b exp 0000", overflow_o);
        end
        checks++;
        if (skew_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_skew_err got %b exp 0", skew_err_o);
        end
        drive('0, '0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        model_reset();
        model_step();
    endtask

    task automatic test_deskew();
        logic [NL-1:0] lv;
        clear_cycle();
        for (int c = 0; c < 9; c++) begin
            lv = '0;
            if (c == 0) lv[0] = 1'b1;
            if (c == 2) lv[1] = 1'b1;
            if (c == 3) lv[2] = 1'b1;
            if (c == 5) lv[3] = 1'b1;
            drive(lv, 32'hA3A2_A1A0, 1'b1, 1'b0);
            checks++;
            if (valid_o !== (c == 6)) begin
                errors++; $display("FAIL deskew_valid cycle %0d got %b exp %b", c, valid_o, c == 6);
            end
            if (c == 6) begin
                checks++;
                if (data_o !== 32'hA3A2_A1A0) begin
                    errors++; $display("FAIL deskew_data got %h exp a3a2a1a0", data_o);
                end
            end
            model_step();
        end
    endtask

    task automatic test_overflow();
        logic [NL-1:0] exp_ovf;
        clear_cycle();
        for (int c = 0; c < 7; c++) begin
            drive((c < 5) ? 4'b0010 : 4'b0000, DW'($urandom), 1'b0, 1'b0);
            exp_ovf = (c >= 5) ? 4'b0010 : 4'b0000;
            checks++;
            if (overflow_o !== exp_ovf || m_ovf !== exp_ovf) begin
                errors++; $display("FAIL overflow_flag cycle %0d got %b exp %b", c, overflow_o, exp_ovf);
            end
            checks++;
            if (valid_o !== 1'b0) begin
                errors++; $display("FAIL overflow_valid cycle %0d got %b exp 0", c, valid_o);
            end
            model_step();
        end
    endtask

    task automatic test_skew_timeout();
        logic [NL-1:0] lv;
        logic [DW-1:0] ld;
        clear_cycle();
        for (int c = 0; c < 14; c++) begin
            lv = '0;
            ld = DW'($urandom);
            if (c == 0)  lv = 4'b0001;
            if (c == 10) lv = 4'b1110;
            if (c == 11) begin
                lv = 4'b0001;
                ld[7:0] = 8'h55;
            end
            drive(lv, ld, 1'b1, 1'b0);
            checks++;
            if (skew_err_o !== (c >= 10)) begin
                errors++; $display("FAIL skew_err cycle %0d got %b exp %b", c, skew_err_o, c >= 10);
            end
            checks++;
            if (valid_o !== (c == 12)) begin
                errors++; $display("FAIL skew_valid cycle %0d got %b exp %b", c, valid_o, c == 12);
            end
            if (c == 12) begin
                checks++;
                if (data_o[7:0] !== 8'h55 || data_o !== m_data()) begin
                    errors++; $display("FAIL skew_fresh_data got %h exp %h", data_o, m_data());
                end
            end
            model_step();
        end
    endtask

    task automatic test_full_push_pop();
        clear_cycle();
        for (int c = 0; c < 17; c++) begin
            drive((c < 12) ? 4'b1111 : 4'b0000, DW'($urandom), c >= 4, 1'b0);
            checks++;
            if (valid_o !== (c >= 1 && c <= 15)) begin
                errors++; $display("FAIL full_valid cycle %0d got %b exp %b", c, valid_o, c >= 1 && c <= 15);
            end
            if (valid_o === 1'b1) begin
                checks++;
                if (data_o !== m_data()) begin
                    errors++; $display("FAIL full_data cycle %0d got %h exp %h", c, data_o, m_data());
                end
            end
            checks++;
            if (overflow_o !== 4'b0000) begin
                errors++; $display("FAIL full_overflow cycle %0d got %b exp 0000", c, overflow_o);
            end
            model_step();
        end
    endtask

    task automatic test_clear();
        clear_cycle();
        for (int c = 0; c < 22; c++) begin
            drive((c < 5 || c == 7) ? 4'b0001 : 4'b0000, DW'($urandom), 1'b0, c == 6);
            if (c == 5) begin
                checks++;
                if (overflow_o !== 4'b0001) begin
                    errors++; $display("FAIL clear_pre_ovf got %b exp 0001", overflow_o);
                end
            end
            if (c == 7) begin
                checks++;
                if (overflow_o !== 4'b0000 || skew_err_o !== 1'b0 || valid_o !== 1'b0) begin
                    errors++; $display("FAIL clear_flags ovf %b err %b valid %b exp 0000 0 0",
                                       overflow_o, skew_err_o, valid_o);
                end
            end
            // Lane 0 refilled right after clear must time out a full window later.
            checks++;
            if (skew_err_o !== m_skerr || skew_err_o !== (c >= 17)) begin
                errors++; $display("FAIL clear_skew_window cycle %0d got %b exp %b", c, skew_err_o, c >= 17);
            end
            model_step();
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ld;
        clear_cycle();
        drive(4'b1111, DW'($urandom), 1'b0, 1'b0);
        model_step();
        drive(4'b1111, DW'($urandom), 1'b0, 1'b0);
        model_step();
        drive('0, '0, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre_valid got %b exp 1", valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_valid got %b exp 0", valid_o);
        end
        model_reset();
        drive('0, '0, 1'b1, 1'b0);
        rst_ni = 1'b1;
        model_step();
        for (int c = 0; c < 6; c++) begin
            ld = 32'hC3C2_C1C0;
            drive((c < 4) ? NL'(1 << c) : '0, ld, 1'b1, 1'b0);
            checks++;
            if (valid_o !== (c == 4)) begin
                errors++; $display("FAIL rstmid_valid cycle %0d got %b exp %b", c, valid_o, c == 4);
            end
            if (c == 4) begin
                checks++;
                if (data_o !== 32'hC3C2_C1C0) begin
                    errors++; $display("FAIL rstmid_data got %h exp c3c2c1c0", data_o);
                end
            end
            model_step();
        end
    endtask

    task automatic test_random();
        logic [NL-1:0] lv;
        int            pct;
        clear_cycle();
        for (int c = 0; c < 1200; c++) begin
            pct = (c < 400) ? 70 : (c < 800) ? 30 : 85;
            lv = '0;
            for (int k = 0; k < NL; k++) lv[k] = ($urandom_range(99) < pct);
            drive(lv, DW'($urandom), $urandom_range(99) < 65, $urandom_range(99) < 2);
            checks++;
            if (valid_o !== m_all_ne()) begin
                errors++; $display("FAIL rand_valid cycle %0d got %b exp %b", c, valid_o, m_all_ne());
            end
            if (m_all_ne()) begin
                checks++;
                if (data_o !== m_data()) begin
                    errors++; $display("FAIL rand_data cycle %0d got %h exp %h", c, data_o, m_data());
                end
            end
            checks++;
            if (overflow_o !== m_ovf || skew_err_o !== m_skerr) begin
                errors++; $display("FAIL rand_flags cycle %0d got %b/%b exp %b/%b",
                                   c, overflow_o, skew_err_o, m_ovf, m_skerr);
            end
            model_step();
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        ready_i      = 1'b0;
        lane_valid_i = '0;
        lane_data_i  = '0;
        model_reset();
        test_reset();
        test_deskew();
        test_overflow();
        test_skew_timeout();
        test_full_push_pop();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
